// File: rtl/counter_pkg.sv
// Shared types, error codes and modular-increment helper for the decade-counter checker.
`timescale 1ns/1ps
package counter_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_SEQ   = 2'b10;
  localparam logic [1:0] E_CARRY = 2'b11;

  // Value that must follow v in a modulo-`modulus` count sequence.
  function automatic logic [15:0] next_mod(input logic [15:0] v, input int unsigned modulus);
    logic [16:0] w_inc;
    w_inc = {1'b0, v} + 17'd1;
    if (w_inc >= 17'(modulus)) return '0;
    return w_inc[15:0];
  endfunction

endpackage

// File: rtl/counter10_checker_if.sv
// Monitored counter signals plus checker status outputs, shared by checker and stimulus side.
`timescale 1ns/1ps
interface counter10_checker_if #(
  parameter int CNT_W  = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
) ();
  logic [CNT_W-1:0]  cnt;
  logic              cout;
  logic              clr;
  logic              locked;
  logic              err;
  logic [1:0]        err_code;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (output cnt, cout, clr,
                  input  locked, err, err_code, err_cnt, wrap_cnt);
  modport slave  (input  cnt, cout, clr,
                  output locked, err, err_code, err_cnt, wrap_cnt);
endinterface

// File: rtl/counter10_checker_rule_chk.sv
// Combinational sample classifier: range, carry and sequence checks with a fixed priority.
`timescale 1ns/1ps
module counter10_rule_chk
  import counter_pkg::*;
#(
  parameter int MODULUS = 10,
  parameter int CNT_W   = 4
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_cout,
  input  logic [CNT_W-1:0] i_prev,
  input  logic             i_seq_en,
  output logic             o_rc_err,
  output logic             o_err,
  output logic [1:0]       o_code
);
  // One extra bit so MODULUS == 2**CNT_W still compares correctly.
  localparam logic [CNT_W:0]   LP_MOD  = (CNT_W+1)'(MODULUS);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MODULUS - 1);

  logic             w_range;
  logic             w_carry;
  logic             w_seq;
  logic [CNT_W-1:0] w_expect;

  always_comb begin
    w_expect = CNT_W'(next_mod(16'(i_prev), MODULUS));
    w_range  = ({1'b0, i_cnt} >= LP_MOD);
    w_carry  = (i_cout != (i_cnt == LP_LAST));
    w_seq    = i_seq_en && (i_cnt != w_expect);
    o_rc_err = w_range || w_carry;
    if (w_range)      o_code = E_RANGE;
    else if (w_carry) o_code = E_CARRY;
    else if (w_seq)   o_code = E_SEQ;
    else              o_code = E_NONE;
    o_err = (o_code != E_NONE);
  end

endmodule

// File: rtl/counter10_checker.sv
// Passive decade-counter monitor: lock FSM, acquisition run counter, error/wrap statistics.
//   state  | meaning
//   SYNC   | hunting for a clean 0 sample to start acquisition
//   ACQ    | counting consecutive clean samples toward LOCK_LEN
//   LOCKED | full checking including sequence; any error leaves
//   FAULT  | single recovery cycle after a locked error, then SYNC
`timescale 1ns/1ps
module counter10_checker
  import counter_pkg::*;
#(
  parameter int MODULUS  = 10,
  parameter int CNT_W    = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16,
  parameter int LOCK_LEN = 2
) (
  input  logic                clk,
  input  logic                rstn,
  counter10_checker_if.slave  bus
);
  localparam int               RUN_W   = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LP_LOCK = RUN_W'(LOCK_LEN);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MODULUS - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_prev;
  logic [RUN_W-1:0]  r_run;
  logic              r_locked;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [WRAP_W-1:0] r_wrap_cnt;

  state_t            w_next_state;
  logic [RUN_W-1:0]  w_next_run;
  logic [RUN_W-1:0]  w_run_inc;
  logic              w_rc_err;
  logic              w_err;
  logic [1:0]        w_code;
  logic              w_wrap_hit;

  counter10_rule_chk #(.MODULUS(MODULUS), .CNT_W(CNT_W)) u_rule_chk (
    .i_cnt    (bus.cnt),
    .i_cout   (bus.cout),
    .i_prev   (r_prev),
    .i_seq_en (r_state == LOCKED),
    .o_rc_err (w_rc_err),
    .o_err    (w_err),
    .o_code   (w_code)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_run   = r_run;
    w_run_inc    = r_run + RUN_W'(1);
    case (r_state)
      SYNC: begin
        if (!w_rc_err && (bus.cnt == '0)) begin
          w_next_run   = RUN_W'(1);
          w_next_state = (LOCK_LEN == 1) ? LOCKED : ACQ;
        end
      end
      ACQ: begin
        if (w_rc_err) begin
          w_next_run   = '0;
          w_next_state = SYNC;
        end else begin
          w_next_run = w_run_inc;
          if (w_run_inc == LP_LOCK) w_next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (w_err) w_next_state = FAULT;
      end
      FAULT: begin
        w_next_run   = '0;
        w_next_state = SYNC;
      end
      default: begin
        w_next_run   = '0;
        w_next_state = SYNC;
      end
    endcase
    w_wrap_hit = (r_state == LOCKED) && !w_err && (bus.cnt == '0) && (r_prev == LP_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= SYNC;
      r_prev     <= '0;
      r_run      <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_run    <= w_next_run;
      r_prev   <= bus.cnt;
      r_locked <= (w_next_state == LOCKED);
      r_err    <= w_err;
      if (w_err) r_err_code <= w_code;
      // A same-cycle error outranks the clear, leaving a count of one.
      if (w_err) begin
        if (bus.clr)         r_err_cnt <= ERR_W'(1);
        else if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (bus.clr) begin
        r_err_cnt <= '0;
      end
      if (bus.clr)         r_wrap_cnt <= '0;
      else if (w_wrap_hit) r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  assign bus.locked   = r_locked;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
  assign bus.err_cnt  = r_err_cnt;
  assign bus.wrap_cnt = r_wrap_cnt;

endmodule
